game_input_tick: RTL and testbench

//  Parametrised input-conditioning and game-timing block for the Tetris top. It replaces the raw
//  Btn* wiring and the fixed DIV_CLK[23] game clock. Per button: 2-FF synchroniser, debouncer,

---
 rtl/game_input_tick.sv | 211 +++++++++++++++++++++
 tb/tb_game_input_tick.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/game_input_tick.sv
`default_nettype none
// ============================================================================
// Module   : game_input_tick
// Purpose  : Button conditioning and game timing for the Tetris top.
//            Per channel: 2-FF synchroniser, debouncer, press/release pulses
//            and an auto-repeat FSM. Also produces a level-scaled one-cycle
//            game tick enable so game logic runs on Clk with an enable.
// Ports    : Clk        - system clock
//            Reset_n    - synchronous reset, active low
//            btn_raw    - asynchronous raw buttons
//            repeat_en  - per-channel auto-repeat enable
//            level      - game speed level
//            tick_en    - 1 = tick counter runs, 0 = counter held at 0
//            btn_level  - debounced button state
//            btn_press  - 1-cycle pulse on debounced rise
//            btn_rel    - 1-cycle pulse on debounced fall
//            btn_act    - 1-cycle action pulse (press plus auto-repeats)
//            tick       - 1-cycle game tick enable
// Revision : 1.0 - initial release
// ============================================================================
module game_input_tick #(
    parameter int NUM_BTN          = 5,
    parameter int DEBOUNCE_CYC     = 1_000_000,
    parameter int REPEAT_DELAY_CYC = 25_000_000,
    parameter int REPEAT_RATE_CYC  = 5_000_000,
    parameter int LEVEL_W          = 4,
    parameter int TICK_BASE        = 16_777_216,
    parameter int TICK_STEP        = 1_048_576,
    parameter int TICK_MIN         = 2_097_152
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_BTN-1:0] repeat_en,
    input  logic [LEVEL_W-1:0] level,
    input  logic               tick_en,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_rel,
    output logic [NUM_BTN-1:0] btn_act,
    output logic               tick
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYC);
    localparam int RC_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int RC_W   = $clog2(RC_MAX + 1);

    localparam logic [DB_W-1:0] c_db_last    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [RC_W-1:0] c_delay_last = RC_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [RC_W-1:0] c_rate_last  = RC_W'(REPEAT_RATE_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RPT   = 2'd2
    } rpt_state_t;

    // ------------------------------------------------------------------
    // Two-stage synchroniser for all channels
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] r_s1;
    logic [NUM_BTN-1:0] r_s2;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= btn_raw;
            r_s2 <= r_s1;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce, edge pulses and auto-repeat
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic [DB_W-1:0] r_cnt;
        logic            r_stable;
        logic            r_press;
        logic            r_rel;
        logic            r_act;
        rpt_state_t      r_state;
        logic [RC_W-1:0] r_rc;

        logic w_diff;
        logic w_flip;
        logic w_rise;
        logic w_fall;

        assign w_diff = (r_s2[i] != r_stable);
        assign w_flip = w_diff && (r_cnt == c_db_last);
        // Edge pulses are derived from the flip itself so that they line up
        // with the first cycle btn_level shows the new value.
        assign w_rise = w_flip && r_s2[i];
        assign w_fall = w_flip && !r_s2[i];

        always_ff @(posedge Clk) begin
            if (!Reset_n) begin
                r_cnt    <= '0;
                r_stable <= 1'b0;
                r_press  <= 1'b0;
                r_rel    <= 1'b0;
                r_act    <= 1'b0;
                r_state  <= ST_IDLE;
                r_rc     <= '0;
            end else begin
                r_press <= w_rise;
                r_rel   <= w_fall;
                r_act   <= 1'b0;

                if (w_diff) begin
                    if (w_flip) begin
                        r_stable <= ~r_stable;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end

                case (r_state)
                    ST_IDLE: begin
                        if (w_rise) begin
                            r_act   <= 1'b1;
                            r_rc    <= '0;
                            r_state <= repeat_en[i] ? ST_DELAY : ST_IDLE;
                        end
                    end
                    ST_DELAY: begin
                        if (w_fall || !repeat_en[i]) begin
                            r_state <= ST_IDLE;
                            r_rc    <= '0;
                        end else if (r_rc == c_delay_last) begin
                            r_act   <= 1'b1;
                            r_rc    <= '0;
                            r_state <= ST_RPT;
                        end else begin
                            r_rc <= r_rc + 1'b1;
                        end
                    end
                    ST_RPT: begin
                        if (w_fall || !repeat_en[i]) begin
                            r_state <= ST_IDLE;
                            r_rc    <= '0;
                        end else if (r_rc == c_rate_last) begin
                            r_act <= 1'b1;
                            r_rc  <= '0;
                        end else begin
                            r_rc <= r_rc + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_rc    <= '0;
                    end
                endcase
            end
        end

        assign btn_level[i] = r_stable;
        assign btn_press[i] = r_press;
        assign btn_rel[i]   = r_rel;
        assign btn_act[i]   = r_act;
    end

    // ------------------------------------------------------------------
    // Game tick: period = max(TICK_BASE - level*TICK_STEP, TICK_MIN)
    // ------------------------------------------------------------------
    logic [31:0] w_dec;
    logic [31:0] w_diff_p;
    logic [31:0] w_period;
    logic [31:0] r_tcnt;
    logic        r_tick;

    always_comb begin
        w_dec    = 32'(level) * 32'(TICK_STEP);
        w_diff_p = 32'(TICK_BASE) - w_dec;
        // A reduction at or beyond the base would go negative; clamp instead.
        if (w_dec >= 32'(TICK_BASE)) begin
            w_period = 32'(TICK_MIN);
        end else if (w_diff_p < 32'(TICK_MIN)) begin
            w_period = 32'(TICK_MIN);
        end else begin
            w_period = w_diff_p;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_tcnt <= '0;
            r_tick <= 1'b0;
        end else if (!tick_en) begin
            r_tcnt <= '0;
            r_tick <= 1'b0;
        end else if (r_tcnt >= w_period - 32'd1) begin
            // ">=" catches a level change that shrank the period below the
            // current count: fire now rather than overrun.
            r_tcnt <= '0;
            r_tick <= 1'b1;
        end else begin
            r_tcnt <= r_tcnt + 32'd1;
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_game_input_tick.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_input_tick
// Purpose  : Directed self-checking bench for game_input_tick with small
//            timing parameters. Expected pulse positions are hand-computed
//            and stored as bit masks indexed by clock edge number.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_input_tick;

    localparam int NUM_BTN = 5;
    localparam int LEVEL_W = 4;

    logic               clk;
    logic               rst_n;
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] repeat_en;
    logic [LEVEL_W-1:0] level;
    logic               tick_en;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_rel;
    logic [NUM_BTN-1:0] btn_act;
    logic               tick;

    int checks   = 0;
    int failures = 0;

    logic [63:0] m_act;
    logic [63:0] m_press;
    logic [63:0] m_rel;
    logic [63:0] m_tick;

    game_input_tick #(
        .NUM_BTN          (NUM_BTN),
        .DEBOUNCE_CYC     (4),
        .REPEAT_DELAY_CYC (10),
        .REPEAT_RATE_CYC  (3),
        .LEVEL_W          (LEVEL_W),
        .TICK_BASE        (16),
        .TICK_STEP        (4),
        .TICK_MIN         (4)
    ) dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .btn_raw   (btn_raw),
        .repeat_en (repeat_en),
        .level     (level),
        .tick_en   (tick_en),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .btn_rel   (btn_rel),
        .btn_act   (btn_act),
        .tick      (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs n cycles; bit j of each mask records the output after edge j.
    task automatic run(input int n, input int ch);
        m_act   = '0;
        m_press = '0;
        m_rel   = '0;
        m_tick  = '0;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            m_act[j]   = btn_act[ch];
            m_press[j] = btn_press[ch];
            m_rel[j]   = btn_rel[ch];
            m_tick[j]  = tick;
        end
    endtask

    initial begin
        logic glitch_seen;

        // 1: reset with all buttons held, then debounce as fresh press
        rst_n     = 1'b0;
        btn_raw   = 5'h1F;
        repeat_en = 5'h00;
        level     = '0;
        tick_en   = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {44'd0, btn_level, btn_press, btn_rel, btn_act},
            64'd0);
        chk("reset_tick", {63'd0, tick}, 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("level_before_edge6", {59'd0, btn_level}, 64'd0);
        @(negedge clk);
        chk("level_edge6", {59'd0, btn_level}, 64'h1F);
        chk("press_edge6", {59'd0, btn_press}, 64'h1F);
        chk("act_edge6", {59'd0, btn_act}, 64'h1F);
        @(negedge clk);
        chk("press_one_cycle", {54'd0, btn_press, btn_act}, 64'd0);

        // release all: btn_rel for one cycle, no act
        btn_raw = 5'h00;
        repeat (6) @(negedge clk);
        chk("rel_all_level", {59'd0, btn_level}, 64'd0);
        chk("rel_all_pulse", {59'd0, btn_rel}, 64'h1F);
        chk("rel_all_noact", {59'd0, btn_act}, 64'd0);
        @(negedge clk);
        chk("rel_one_cycle", {59'd0, btn_rel}, 64'd0);

        // 2: 3-cycle glitch on channel 0 is rejected
        glitch_seen = 1'b0;
        btn_raw[0]  = 1'b1;
        for (int j = 0; j < 12; j++) begin
            if (j == 3) btn_raw[0] = 1'b0;
            @(negedge clk);
            glitch_seen = glitch_seen | btn_level[0] | btn_press[0] | btn_act[0];
        end
        chk("glitch_rejected", {63'd0, glitch_seen}, 64'd0);

        // 3: hold channel 1 with repeat, release after 30 cycles
        repeat_en[1] = 1'b1;
        btn_raw[1]   = 1'b1;
        run(30, 1);
        begin
            logic [63:0] a1;
            logic [63:0] p1;
            a1 = m_act;
            p1 = m_press;
            btn_raw[1] = 1'b0;
            run(15, 1);
            // edges 31..45 land at bits 31..45
            a1 = a1 | (m_act << 30);
            chk("repeat_act_pattern", a1,
                (64'd1 << 6) | (64'd1 << 16) | (64'd1 << 19) | (64'd1 << 22) |
                (64'd1 << 25) | (64'd1 << 28) | (64'd1 << 31) | (64'd1 << 34));
            chk("repeat_press_once", p1 | (m_press << 30), 64'd1 << 6);
            chk("repeat_rel_once", m_rel << 30, 64'd1 << 36);
        end

        // 4: same hold without repeat
        repeat_en[1] = 1'b0;
        btn_raw[1]   = 1'b1;
        run(30, 1);
        chk("norepeat_act", m_act, 64'd1 << 6);
        btn_raw[1] = 1'b0;
        run(15, 1);
        chk("norepeat_rel", m_rel, 64'd1 << 6);
        chk("norepeat_noact", m_act, 64'd0);

        // 5: tick at level 0 (period 16), switch to level 3 at tcnt=10
        level   = 4'd0;
        tick_en = 1'b1;
        run(42, 0);
        chk("tick_level0", m_tick, (64'd1 << 16) | (64'd1 << 32));
        level = 4'd3;
        run(14, 0);
        // edges 43..56 relative to enable -> bits 1..14 here
        chk("tick_level3", m_tick, (64'd1 << 1) | (64'd1 << 5) | (64'd1 << 9) | (64'd1 << 13));
        level = 4'd15;
        run(12, 0);
        chk("tick_level15_clamp", m_tick, (64'd1 << 3) | (64'd1 << 7) | (64'd1 << 11));
        level = 4'd2;
        run(16, 0);
        chk("tick_level2", m_tick, (64'd1 << 7) | (64'd1 << 15));

        // 6: disable 20 cycles, then re-enable at period 8
        tick_en = 1'b0;
        run(20, 0);
        chk("tick_disabled", m_tick, 64'd0);
        tick_en = 1'b1;
        run(17, 0);
        chk("tick_reenable", m_tick, (64'd1 << 8) | (64'd1 << 16));

        // reset in the middle of DELAY on channel 2
        repeat_en[2] = 1'b1;
        btn_raw[2]   = 1'b1;
        run(8, 2);
        begin
            logic [63:0] a2;
            a2 = m_act;
            rst_n = 1'b0;
            @(negedge clk);
            chk("midreset_outputs", {43'd0, btn_level, btn_press, btn_rel, btn_act, tick},
                64'd0);
            a2[9] = btn_act[2];
            run(3, 2);
            a2 = a2 | (m_act << 9);
            rst_n = 1'b1;
            run(14, 2);
            a2 = a2 | (m_act << 12);
            chk("midreset_act", a2, (64'd1 << 6) | (64'd1 << 18));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
